// File: rtl/cas_pkg.sv
// cas_pkg: state encoding and default widths shared by the cassette upload and download paths
package cas_pkg;
  localparam int CAS_ADDR_W = 16;
  localparam int CAS_LEN_W = 14;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, READY, DONE} cas_state_e;
endpackage

// File: rtl/cas_upload_if.sv
// cas_upload_if: core RAM read port and hps_io ioctl upload signals
interface cas_upload_if import cas_pkg::*; #(parameter int ADDR_W = CAS_ADDR_W);
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_din;
  logic ioctl_upload;
  logic ioctl_rd;
  logic [7:0] ioctl_din;
  logic ioctl_wait;
  modport master(output mem_addr, mem_rd, ioctl_upload, ioctl_din, ioctl_wait, input mem_din, ioctl_rd);
  modport slave(input mem_addr, mem_rd, ioctl_upload, ioctl_din, ioctl_wait, output mem_din, ioctl_rd);
endinterface

// File: rtl/cas_upload.sv
// cas_upload: streams a cassette image from core RAM to the HPS over the ioctl upload path
module cas_upload import cas_pkg::*; #(
  parameter int ADDR_W = CAS_ADDR_W,
  parameter int LEN_W = CAS_LEN_W
) (
  input logic clk_sys,
  input logic reset_n,
  input logic start,
  input logic abort,
  input logic [ADDR_W-1:0] base,
  input logic [LEN_W-1:0] length,
  output logic busy,
  output logic done,
  output logic err,
  cas_upload_if.master io
);
  cas_state_e state, state_n;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0] len_r, ptr, cnt, cnt_inc;
  logic accept;
  assign accept = state == IDLE && start && !abort;
  assign cnt_inc = cnt + LEN_W'(1);
  assign io.mem_rd = state == FETCH;
  assign io.mem_addr = state == FETCH ? base_r + ADDR_W'(ptr) : '0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? (length == '0 ? DONE : FETCH) : IDLE;
      FETCH: state_n = LATCH;
      LATCH: state_n = READY;
      READY: state_n = io.ioctl_rd ? (cnt_inc == len_r ? DONE : FETCH) : READY;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  // outputs register the decode of the next state so they line up with state
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= IDLE;
      base_r <= '0;
      len_r <= '0;
      ptr <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      io.ioctl_upload <= 1'b0;
      io.ioctl_wait <= 1'b0;
      io.ioctl_din <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      io.ioctl_upload <= state_n inside {FETCH, LATCH, READY};
      io.ioctl_wait <= state_n inside {FETCH, LATCH};
      err <= accept ? 1'b0 : err | (io.ioctl_rd && !abort && state inside {FETCH, LATCH});
      if (accept) begin
        base_r <= base;
        len_r <= length;
        ptr <= '0;
        cnt <= '0;
      end
      if (state == LATCH) io.ioctl_din <= io.mem_din;
      if (state == READY && io.ioctl_rd && !abort) begin
        cnt <= cnt_inc;
        ptr <= state_n == FETCH ? ptr + LEN_W'(1) : ptr;
      end
    end
  end
endmodule

// File: tb/tb_cas_upload.sv
// tb_cas_upload: scoreboard bench; stimulus queues expected bytes/addresses, a negedge monitor checks them
module tb_cas_upload;
  logic clk_sys = 1'b0;
  logic reset_n, start, abort;
  logic [15:0] base;
  logic [13:0] length;
  logic busy, done, err;
  logic [7:0] ram [0:65535];
  logic [7:0] exp_q[$];
  logic [15:0] addr_q[$];
  int checks = 0, errors = 0, done_cnt = 0;

  cas_upload_if #(.ADDR_W(16)) u();
  cas_upload #(.ADDR_W(16), .LEN_W(14)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
    .base(base), .length(length), .busy(busy), .done(done), .err(err), .io(u)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (u.mem_rd) u.mem_din <= ram[u.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_sys) begin
    if (u.ioctl_rd && u.ioctl_upload && !u.ioctl_wait) begin
      if (exp_q.size() == 0) check("byte_unexpected", u.ioctl_din, 32'hFFFF_FFFF);
      else check("byte", u.ioctl_din, exp_q.pop_front());
    end
    if (u.mem_rd && addr_q.size() > 0) check("mem_addr", u.mem_addr, addr_q.pop_front());
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic go(input logic [15:0] b, input logic [13:0] l);
    base = b;
    length = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic consume(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!(u.ioctl_upload && !u.ioctl_wait) && t < 20) begin
        step();
        t++;
      end
      if (t == 20) begin
        check("consume_timeout", t, 0);
        return;
      end
      u.ioctl_rd = 1'b1;
      step();
      u.ioctl_rd = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; length = '0; u.ioctl_rd = 1'b0;
    foreach (ram[i]) ram[i] = 8'h00;
    repeat (3) step();
    check("reset_ctl", {busy, done, err, u.mem_rd, u.ioctl_upload, u.ioctl_wait}, 0);
    check("reset_data", {u.ioctl_din, u.mem_addr}, 0);
    reset_n = 1'b1;
    step();
    // three-byte upload with latency check
    ram[16'h4000] = 8'hA1; ram[16'h4001] = 8'hB2; ram[16'h4002] = 8'hC3;
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    addr_q = '{16'h4000, 16'h4001, 16'h4002};
    go(16'h4000, 14'd3);
    check("lat_fetch_wait", {u.ioctl_upload, u.ioctl_wait, busy}, 3'b111);
    step();
    check("lat_latch_wait", u.ioctl_wait, 1);
    step();
    check("lat_ready", {u.ioctl_upload, u.ioctl_wait, u.ioctl_din}, {2'b10, 8'hA1});
    consume(3);
    check("done_pulse", {done, u.ioctl_upload}, 2'b10);
    step();
    check("after_done", {done, busy}, 0);
    check("done_cnt_a", done_cnt, 1);
    // zero length
    go(16'h1234, 14'd0);
    check("zero_len_done", {busy, done, u.ioctl_upload}, 3'b110);
    step();
    check("zero_len_idle", {busy, done, u.ioctl_upload}, 0);
    check("done_cnt_b", done_cnt, 2);
    // address wrap
    ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'h6B;
    exp_q = '{8'h5A, 8'h6B};
    addr_q = '{16'hFFFF, 16'h0000};
    go(16'hFFFF, 14'd2);
    consume(2);
    check("wrap_done", done, 1);
    step();
    check("done_cnt_c", done_cnt, 3);
    check("addr_q_empty", addr_q.size(), 0);
    // abort after two of five bytes, with err set first
    for (int i = 0; i < 5; i++) ram[16'h1000 + i] = 8'h30 + 8'(i);
    exp_q = '{8'h30, 8'h31};
    go(16'h1000, 14'd5);
    u.ioctl_rd = 1'b1;
    step();
    u.ioctl_rd = 1'b0;
    check("err_fetch_rd", err, 1);
    consume(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, done, u.ioctl_upload}, 0);
    check("abort_err_sticky", err, 1);
    step(); step();
    check("done_cnt_abort", done_cnt, 3);
    ram[16'h2000] = 8'h77;
    exp_q = '{8'h77};
    go(16'h2000, 14'd1);
    check("start_clears_err", err, 0);
    consume(1);
    check("len1_done", done, 1);
    step();
    check("done_cnt_d", done_cnt, 4);
    // ioctl_rd during LATCH
    ram[16'h3000] = 8'h11; ram[16'h3001] = 8'h22;
    exp_q = '{8'h11, 8'h22};
    go(16'h3000, 14'd2);
    step();
    u.ioctl_rd = 1'b1;
    step();
    u.ioctl_rd = 1'b0;
    check("err_latch_rd", err, 1);
    consume(1);
    check("count_unchanged", {done, busy}, 2'b01);
    consume(1);
    check("latch_rd_done", done, 1);
    step();
    check("done_cnt_e", done_cnt, 5);
    // abort wins over start in IDLE
    abort = 1'b1; start = 1'b1; length = 14'd3;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", {busy, u.ioctl_upload}, 0);
    // reset mid-upload
    go(16'h3100, 14'd4);
    step(); step();
    check("pre_reset_ready", {u.ioctl_upload, u.ioctl_wait}, 2'b10);
    reset_n = 1'b0;
    step();
    check("midreset_ctl", {busy, done, err, u.mem_rd, u.ioctl_upload, u.ioctl_wait}, 0);
    check("midreset_data", {u.ioctl_din, u.mem_addr}, 0);
    reset_n = 1'b1;
    step(); step();
    check("done_cnt_f", done_cnt, 5);
    check("byte_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
